mprj_checkpoint_monitor: RTL and testbench

//  Synthesizable, parametrised checkpoint-sequence monitor for the user project's mprj_io checkbits bus.

---
 rtl/mprj_checkpoint_monitor_pkg.sv | 16 +
 rtl/mprj_checkpoint_monitor_filter.sv | 56 +++++
 rtl/mprj_checkpoint_monitor.sv | 166 ++++++++++++++++
 tb/tb_mprj_checkpoint_monitor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_checkpoint_monitor_pkg.sv
// Shared types for the checkpoint-sequence monitor.
// FSM state encoding and failure-reason codes.
package mprj_checkpoint_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
  localparam logic [1:0] FAIL_ORDER   = 2'd2;

endpackage

// File: rtl/mprj_checkpoint_monitor_filter.sv
// Masked code compare plus STABLE-cycle glitch filter with re-arm.
// Ports: clk/rst, en (count), rearm, clr, checkbits, code, mask -> stable_hit.
module mprj_checkpoint_monitor_filter
  import mprj_checkpoint_monitor_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STABLE = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic             rearm,
  input  logic             clr,
  input  logic [WIDTH-1:0] checkbits,
  input  logic [WIDTH-1:0] code,
  input  logic [WIDTH-1:0] mask,
  output logic             stable_hit
);

  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

  logic          match;
  logic          armed_q;
  logic [CW-1:0] cnt_q;

  assign match = ((checkbits ^ code) & mask) == '0;

  assign stable_hit = en & match & armed_q &
                      (cnt_q == CW'(STABLE - 1));

  // A filter that sees its code at a stage change is disarmed
  // until the bus leaves the code, so duplicates need a gap.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (rearm) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (clr) begin
      cnt_q   <= '0;
      armed_q <= ~match;
    end else if (en) begin
      if (!match) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else if (stable_hit) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else if (armed_q) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint-sequence monitor: ordered codes, timeout, order check.
// Ports: wb clk/rst, arm/clear, checkbits, codes, mask -> busy/pass/fail/stage/adv/lat.
module mprj_checkpoint_monitor
  import mprj_checkpoint_monitor_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_CKPT  = 3,
  parameter int CNT_W     = 28,
  parameter int TIMEOUT   = 200000,
  parameter int GLOBAL_TO = 0,
  parameter int STABLE    = 2,
  parameter int STRICT    = 1,
  localparam int SW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      arm_i,
  input  logic                      clear_i,
  input  logic [WIDTH-1:0]          checkbits_i,
  input  logic [NUM_CKPT*WIDTH-1:0] ckpt_codes_i,
  input  logic [WIDTH-1:0]          ckpt_mask_i,
  output logic                      busy_o,
  output logic                      pass_o,
  output logic                      fail_o,
  output logic [1:0]                fail_reason_o,
  output logic [SW-1:0]             stage_o,
  output logic                      stage_adv_o,
  output logic [CNT_W-1:0]          stage_lat_o
);

  state_t             state_q, state_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic               adv_q, adv_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic [1:0]         reason_q, reason_d;

  logic [NUM_CKPT-1:0] hit;
  logic                cur_hit;
  logic                order_hit;
  logic                tout_hit;
  logic                last_stage;
  logic                adv_clr;
  logic                rearm;
  logic                in_wait;
  logic [CNT_W:0]      tcnt_inc;
  logic [CNT_W-1:0]    tcnt_sat;

  assign in_wait    = (state_q == ST_WAIT);
  assign rearm      = arm_i & ~clear_i;
  assign tcnt_inc   = {1'b0, tcnt_q} + (CNT_W+1)'(1);
  assign tcnt_sat   = (&tcnt_q) ? tcnt_q : tcnt_inc[CNT_W-1:0];
  assign tout_hit   = (TIMEOUT != 0) &&
                      (tcnt_inc == (CNT_W+1)'(TIMEOUT));
  assign last_stage = (stage_q == SW'(NUM_CKPT - 1));
  assign cur_hit    = hit[stage_q];

  for (genvar k = 0; k < NUM_CKPT; k++) begin : g_filt
    mprj_checkpoint_monitor_filter #(
      .WIDTH (WIDTH),
      .STABLE(STABLE)
    ) u_filt (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .en        (in_wait),
      .rearm     (rearm),
      .clr       (adv_clr),
      .checkbits (checkbits_i),
      .code      (ckpt_codes_i[k*WIDTH +: WIDTH]),
      .mask      (ckpt_mask_i),
      .stable_hit(hit[k])
    );
  end

  // Any later stage seen stably while an earlier one is awaited.
  always_comb begin
    order_hit = 1'b0;
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (STRICT != 0 && j > int'(stage_q) && hit[j]) begin
        order_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    tcnt_d   = tcnt_q;
    lat_d    = lat_q;
    adv_d    = 1'b0;
    pass_d   = pass_q;
    fail_d   = fail_q;
    reason_d = reason_q;
    adv_clr  = 1'b0;
    if (clear_i) begin
      state_d  = ST_IDLE;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      reason_d = FAIL_NONE;
    end else if (arm_i) begin
      state_d  = ST_WAIT;
      stage_d  = '0;
      tcnt_d   = '0;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      reason_d = FAIL_NONE;
    end else if (in_wait) begin
      tcnt_d = tcnt_sat;
      if (cur_hit) begin
        adv_d = 1'b1;
        lat_d = tcnt_sat;
        if (last_stage) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end else begin
          stage_d = stage_q + SW'(1);
          adv_clr = 1'b1;
          if (GLOBAL_TO == 0) begin
            tcnt_d = '0;
          end
        end
      end else if (order_hit) begin
        state_d  = ST_FAIL;
        fail_d   = 1'b1;
        reason_d = FAIL_ORDER;
      end else if (tout_hit) begin
        state_d  = ST_FAIL;
        fail_d   = 1'b1;
        reason_d = FAIL_TIMEOUT;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      tcnt_q   <= '0;
      lat_q    <= '0;
      adv_q    <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      reason_q <= FAIL_NONE;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      tcnt_q   <= tcnt_d;
      lat_q    <= lat_d;
      adv_q    <= adv_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      reason_q <= reason_d;
    end
  end

  assign busy_o        = in_wait;
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign fail_reason_o = reason_q;
  assign stage_o       = stage_q;
  assign stage_adv_o   = adv_q;
  assign stage_lat_o   = lat_q;

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Directed and random checks of the checkpoint monitor
// against a run-length reference model.
module tb_mprj_checkpoint_monitor;

  localparam int NC = 3;
  localparam int ST = 2;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] bus = 16'h0000;
  logic [15:0] mask = 16'hFFFF;
  logic [47:0] codes_bus = {16'hAB51, 16'hAB41, 16'hAB40};
  logic        busy_o, pass_o, fail_o, stage_adv_o;
  logic [1:0]  fail_reason_o, stage_o;
  logic [27:0] stage_lat_o;

  logic [15:0] codes [NC] = '{16'hAB40, 16'hAB41, 16'hAB51};
  logic [15:0] masks [3]  = '{16'hFFFF, 16'hFFF0, 16'hFF00};

  int n_err = 0;
  int n_chk = 0;
  int adv_seen = 0;

  // reference model
  int  m_state = 0;
  int  m_stage = 0;
  int  m_reason = 0;
  int  m_pass = 0;
  int  m_fail = 0;
  int  m_adv = 0;
  int  m_t = 0;
  int  m_lat = 0;
  int  run [NC];
  bit  fresh [NC];

  always #5 clk = ~clk;

  mprj_checkpoint_monitor #(
    .WIDTH(16), .NUM_CKPT(NC), .CNT_W(28), .TIMEOUT(TO),
    .GLOBAL_TO(0), .STABLE(ST), .STRICT(1)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .arm_i        (arm),
    .clear_i      (clr),
    .checkbits_i  (bus),
    .ckpt_codes_i (codes_bus),
    .ckpt_mask_i  (mask),
    .busy_o       (busy_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .fail_reason_o(fail_reason_o),
    .stage_o      (stage_o),
    .stage_adv_o  (stage_adv_o),
    .stage_lat_o  (stage_lat_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the specified behaviour, from run lengths.
  task automatic model_edge();
    bit m [NC];
    bit h [NC];
    bit later;
    int tn;
    for (int k = 0; k < NC; k++) begin
      m[k] = ((bus ^ codes[k]) & mask) == 16'h0;
      h[k] = 1'b0;
    end
    m_adv = 0;
    if (rst) begin
      m_state = 0; m_stage = 0; m_reason = 0;
      m_pass = 0; m_fail = 0; m_t = 0; m_lat = 0;
      for (int k = 0; k < NC; k++) begin
        run[k] = 0; fresh[k] = 1'b1;
      end
    end else if (clr) begin
      m_state = 0; m_pass = 0; m_fail = 0; m_reason = 0;
    end else if (arm) begin
      m_state = 1; m_stage = 0; m_t = 0;
      m_pass = 0; m_fail = 0; m_reason = 0;
      for (int k = 0; k < NC; k++) begin
        run[k] = 0; fresh[k] = 1'b1;
      end
    end else if (m_state == 1) begin
      later = 1'b0;
      for (int k = 0; k < NC; k++) begin
        if (m[k]) run[k]++;
        else begin
          run[k] = 0; fresh[k] = 1'b1;
        end
        h[k] = fresh[k] && run[k] == ST;
        if (k > m_stage && h[k]) later = 1'b1;
      end
      tn = m_t + 1;
      if (h[m_stage]) begin
        m_adv = 1; m_lat = tn; m_t = tn;
        if (m_stage == NC - 1) begin
          m_state = 2; m_pass = 1;
        end else begin
          m_stage++; m_t = 0;
          for (int k = 0; k < NC; k++)
            if (m[k]) fresh[k] = 1'b0;
        end
      end else if (later) begin
        m_state = 3; m_fail = 1; m_reason = 2; m_t = tn;
      end else if (tn == TO) begin
        m_state = 3; m_fail = 1; m_reason = 1; m_t = tn;
      end else begin
        m_t = tn;
      end
    end
  endtask

  task automatic compare_all();
    chk("busy", 32'(busy_o), 32'(m_state == 1));
    chk("pass", 32'(pass_o), 32'(m_pass));
    chk("fail", 32'(fail_o), 32'(m_fail));
    chk("reason", 32'(fail_reason_o), 32'(m_reason));
    chk("stage", 32'(stage_o), 32'(m_stage));
    chk("adv", 32'(stage_adv_o), 32'(m_adv));
    chk("lat", 32'(stage_lat_o), 32'(m_lat));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (stage_adv_o) adv_seen++;
  endtask

  task automatic drive(input logic [15:0] v, input int n);
    bus = v;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    logic [15:0] val;
    int dur;
    // reset
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_pass", 32'(pass_o), 0);
    chk("rst_fail", 32'(fail_o), 0);
    chk("rst_stage", 32'(stage_o), 0);
    chk("rst_lat", 32'(stage_lat_o), 0);
    rst = 1'b0;
    step();

    // in-order sequence
    pulse_arm();
    chk("arm_busy", 32'(busy_o), 1);
    adv_seen = 0;
    drive(16'hAB40, 5);
    chk("seq_stage1", 32'(stage_o), 1);
    drive(16'hAB41, 5);
    drive(16'hAB51, 5);
    chk("seq_advs", 32'(adv_seen), 3);
    chk("seq_pass", 32'(pass_o), 1);
    chk("seq_lat", 32'(stage_lat_o), 5);

    // per-stage timeout
    pulse_arm();
    drive(16'hAB40, 2);
    drive(16'h0000, 99);
    chk("to_early", 32'(fail_o), 0);
    drive(16'h0000, 1);
    chk("to_fail", 32'(fail_o), 1);
    chk("to_reason", 32'(fail_reason_o), 1);
    chk("to_stage", 32'(stage_o), 1);

    // out of order
    pulse_arm();
    drive(16'hAB40, 2);
    drive(16'hAB51, 2);
    chk("ord_reason", 32'(fail_reason_o), 2);
    chk("ord_stage", 32'(stage_o), 1);

    // glitch filter
    pulse_arm();
    drive(16'hAB40, 1);
    drive(16'h0000, 1);
    chk("glitch_stage", 32'(stage_o), 0);
    drive(16'hAB40, 2);
    chk("glitch_ok", 32'(stage_o), 1);

    // arm mid-wait, then arm+clear in FAIL
    drive(16'hAB41, 2);
    chk("mid_stage2", 32'(stage_o), 2);
    bus = 16'h0000;
    pulse_arm();
    chk("rearm_stage", 32'(stage_o), 0);
    drive(16'hAB40, 2);
    chk("rearm_lat", 32'(stage_lat_o), 2);
    drive(16'hAB51, 2);
    chk("pre_clr_fail", 32'(fail_o), 1);
    arm = 1'b1;
    clr = 1'b1;
    step();
    arm = 1'b0;
    clr = 1'b0;
    chk("clr_busy", 32'(busy_o), 0);
    chk("clr_fail", 32'(fail_o), 0);
    chk("clr_reason", 32'(fail_reason_o), 0);

    // reset mid-sequence
    pulse_arm();
    drive(16'hAB40, 2);
    drive(16'hAB41, 2);
    chk("rst2_pre", 32'(stage_o), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_stage", 32'(stage_o), 0);
    chk("rst2_busy", 32'(busy_o), 0);
    drive(16'hAB51, 3);
    chk("rst2_ignore", 32'(pass_o), 0);

    // masked compare and duplicate re-arm
    mask = 16'hFFF0;
    bus = 16'h0000;
    pulse_arm();
    drive(16'hAB4F, 5);
    chk("dup_hold", 32'(stage_o), 1);
    drive(16'h0000, 1);
    drive(16'hAB41, 2);
    chk("dup_rearm", 32'(stage_o), 2);
    mask = 16'hFFFF;

    // random traffic
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 9) < 7)
        val = codes[$urandom_range(0, NC - 1)];
      else
        val = 16'($urandom);
      dur = $urandom_range(1, 4);
      for (int c = 0; c < dur; c++) begin
        arm = (m_state != 1) ? ($urandom_range(0, 3) == 0)
                             : ($urandom_range(0, 60) == 0);
        clr = ($urandom_range(0, 50) == 0);
        rst = ($urandom_range(0, 300) == 0);
        if (arm && m_state != 1)
          mask = masks[$urandom_range(0, 2)];
        bus = val;
        step();
        arm = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
